// File: rtl/counter_sched_if.sv
// Signal bundle between counter_sched, its two requesters and the shared 3-bit counter.
interface counter_sched_if;
  logic       req0;
  logic       req1;
  logic [2:0] len0;
  logic [2:0] len1;
  logic [2:0] cnt_in;
  logic       t_out;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic       err;

  modport master (
    output req0, req1, len0, len1, cnt_in,
    input  t_out, gnt0, gnt1, done0, done1, busy, err
  );

  modport slave (
    input  req0, req1, len0, len1, cnt_in,
    output t_out, gnt0, gnt1, done0, done1, busy, err
  );
endinterface

// File: rtl/counter_sched.sv
// Two-requester scheduler owning the T input of a shared clear-less 3-bit toggle counter.
// Optional shadow-count checker is compiled in with `define CNT_SCHED_CHECK_EN.
module counter_sched #(
  parameter int FIRST_PRI = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  counter_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Resetting last to the other requester makes FIRST_PRI win the first tie.
  localparam logic LAST_RST = (FIRST_PRI == 0) ? 1'b1 : 1'b0;

  state_t     state_r;
  logic [2:0] start_r;
  logic [2:0] len_r;
  logic       last_r;
  logic       t_out_r;
  logic       gnt0_r;
  logic       gnt1_r;
  logic       done0_r;
  logic       done1_r;
  logic       busy_r;

  logic       win_s;
  logic [2:0] win_len_s;
  logic       cur_req_s;
  logic [2:0] elapsed_s;
  logic       mismatch_s;

  // Arbitration, held-request lookup and modulo-8 progress since the start snapshot
  always_comb begin
    win_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = ~last_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    win_len_s = win_s ? bus.len1 : bus.len0;
    cur_req_s = last_r ? bus.req1 : bus.req0;
    elapsed_s = bus.cnt_in - start_r;
  end

`ifdef CNT_SCHED_CHECK_EN
  logic [2:0] exp_r;
  logic       err_r;

  // Counter disagrees with the shadow count while a grant is active
  always_comb begin
    mismatch_s = 1'b0;
    if (((state_r == RUN) || (state_r == DONE)) && (bus.cnt_in != exp_r)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Shadow count follows the counter from the grant snapshot; error is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= 3'd0;
      err_r <= 1'b0;
    end else begin
      if (state_r == IDLE) begin
        exp_r <= bus.cnt_in;
      end else if ((state_r == RUN) && t_out_r) begin
        exp_r <= exp_r + 3'd1;
      end else begin
        exp_r <= exp_r;
      end
      if (mismatch_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.err = err_r;
`else
  assign mismatch_s = 1'b0;
  assign bus.err    = 1'b0;
`endif

  // Scheduler FSM with registered grant, toggle and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      start_r <= 3'd0;
      len_r   <= 3'd0;
      last_r  <= LAST_RST;
      t_out_r <= 1'b0;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            start_r <= bus.cnt_in;
            len_r   <= win_len_s;
            last_r  <= win_s;
            gnt0_r  <= ~win_s;
            gnt1_r  <= win_s;
            busy_r  <= 1'b1;
            if (win_len_s == 3'd0) begin
              state_r <= DONE;
              t_out_r <= 1'b0;
              done0_r <= ~win_s;
              done1_r <= win_s;
            end else begin
              state_r <= RUN;
              t_out_r <= 1'b1;
              done0_r <= 1'b0;
              done1_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
            t_out_r <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (mismatch_s || !cur_req_s) begin
            state_r <= IDLE;
            t_out_r <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (elapsed_s == (len_r - 3'd1)) begin
            // The final increment lands on this same edge, so DONE sees start + len.
            state_r <= DONE;
            t_out_r <= 1'b0;
            done0_r <= ~last_r;
            done1_r <= last_r;
          end else begin
            state_r <= RUN;
            t_out_r <= 1'b1;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          t_out_r <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          t_out_r <= 1'b0;
          gnt0_r  <= 1'b0;
          gnt1_r  <= 1'b0;
          done0_r <= 1'b0;
          done1_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.t_out = t_out_r;
  assign bus.gnt0  = gnt0_r;
  assign bus.gnt1  = gnt1_r;
  assign bus.done0 = done0_r;
  assign bus.done1 = done1_r;
  assign bus.busy  = busy_r;
endmodule
